// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  // Width able to hold every length from 0 to max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a simultaneous increment.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlapping or not)
// with a registered match pulse and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1001,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b0,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clear,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_len_err
);

  // Stream handshake: a bit is consumed on a rising edge when din_valid=1 and
  // cfg_load=0. There is no ready; the detector accepts every qualified bit.

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  mode_e              mode_q;
  // The oldest history bit is never compared, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               match_q;
  logic               len_err_q;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W-1:0]   len_clamped;
  logic               hit;
  logic               take;

  assign take = din_valid && !cfg_load;

  always_comb begin
    cand = {hist_q, din};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    hit = (len_q != '0)
       && (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q})
       && (((cand ^ pattern_q) & mask) == '0);

    len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    fill_d = fill_q;
    if (hit) begin
      fill_d = (mode_q == MODE_OVL) ? len_q : '0;
    end else if (fill_q < len_q) begin
      fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      mode_q    <= mode_e'(DEF_OVERLAP);
      len_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= len_clamped;
      mode_q    <= mode_e'(cfg_overlap);
      len_err_q <= (len_clamped == '0);
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else if (din_valid) begin
      hist_q    <= cand[MAX_LEN-2:0];
      fill_q    <= fill_d;
      match_q   <= hit;
    end else begin
      match_q   <= 1'b0;
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clear),
    .inc   (take && hit),
    .count (match_count)
  );

  assign match       = match_q;
  assign cfg_len_err = len_err_q;

endmodule
